// File: rtl/des_key_schedule_seq.sv
// des_key_schedule_seq
// Sequential DES key schedule. Accepts a 64-bit key on a valid/ready
// handshake and emits the 16 round keys over a second valid/ready
// handshake: K1..K16 for encryption (left rotations of C/D), K16..K1 for
// decryption (right rotations). PC-1 and PC-2 follow FIPS 46-3, with
// bit 0 as the MSB.
//
// Handshakes: a transfer happens on the rising edge where valid and ready
// are both high. key_ready and rk_valid come only from the state register,
// so neither depends on the partner's valid/ready in the same cycle.
//
// Optional build macro DES_KEY_PARITY_CHECK_EN: when defined, an offered
// key whose bytes do not all have odd parity is consumed, produces a
// one-cycle parity_err pulse and no round keys. When undefined, parity
// bits are ignored and parity_err is tied low.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = RUN).
module des_key_schedule_seq #(
  parameter bit RK_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [0:63] key,
  input  logic        decrypt,
  output logic [0:47] round_key,
  output logic [3:0]  round_num,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        done,
  output logic        parity_err,
  output logic        dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Tables are 1-based bit numbers as printed in FIPS 46-3.
  localparam int PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    r = '0;
    for (int j = 0; j < 56; j++) begin
      r[j] = k[6'(PC1_TAB[j] - 1)];
    end
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    r = '0;
    for (int j = 0; j < 48; j++) begin
      r[j] = cd[6'(PC2_TAB[j] - 1)];
    end
    return r;
  endfunction

  // Shift schedule: rounds 1, 2, 9 and 16 shift by one, all others by two.
  function automatic logic shift_two(input logic [4:0] n);
    return !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
  endfunction

  // Left rotation moves bits toward index 0 (the MSB end).
  function automatic logic [0:27] rotl(input logic [0:27] h, input logic two);
    return two ? {h[2:27], h[0:1]} : {h[1:27], h[0]};
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] h, input logic two);
    return two ? {h[26:27], h[0:25]} : {h[27], h[0:26]};
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [0:55] r_cd;
  logic [4:0]  r_step;
  logic        r_mode;
  logic        r_done;

  logic [0:55] w_pc1;
  logic        w_accept;
  logic        w_load;
  logic        w_hs;
  logic        w_last;
  logic        w_parity_ok;
  logic        w_enc_two;
  logic        w_dec_two;

  assign w_pc1    = pc1(key);
  assign w_accept = key_valid && key_ready;
  assign w_load   = w_accept && w_parity_ok;
  assign w_hs     = rk_valid && rk_ready;
  assign w_last   = w_hs && (r_step == 5'd16);

  // Shift amount for the key after the current one, in each direction.
  assign w_enc_two = shift_two(r_step + 5'd1);
  assign w_dec_two = shift_two(5'd17 - r_step);

`ifdef DES_KEY_PARITY_CHECK_EN
  logic r_perr;

  // Every key byte must carry odd parity.
  always_comb begin
    w_parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^key[8*b +: 8])) w_parity_ok = 1'b0;
    end
  end

  // One-cycle pulse for a consumed key that failed the parity check.
  always_ff @(posedge clk) begin
    if (rst) r_perr <= 1'b0;
    else     r_perr <= w_accept && !w_parity_ok;
  end

  assign parity_err = r_perr;
`else
  logic w_unused_parity;

  assign w_parity_ok     = 1'b1;
  assign parity_err      = 1'b0;
  assign w_unused_parity = ^{key[7], key[15], key[23], key[31],
                             key[39], key[47], key[55], key[63]};
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    key_ready   = 1'b0;
    rk_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        key_ready = 1'b1;
        if (w_load) w_state_nxt = RUN;
      end
      RUN: begin
        rk_valid = 1'b1;
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // C/D rotator, step counter, mode latch and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cd   <= '0;
      r_step <= 5'd1;
      r_mode <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_mode <= decrypt;
        r_step <= 5'd1;
        // Decrypt starts from C0/D0, which equals C16/D16 (total shift 28).
        r_cd   <= decrypt ? w_pc1
                          : {rotl(w_pc1[0:27], 1'b0), rotl(w_pc1[28:55], 1'b0)};
      end else if (w_hs && !w_last) begin
        r_step <= r_step + 5'd1;
        r_cd   <= r_mode ? {rotr(r_cd[0:27], w_dec_two), rotr(r_cd[28:55], w_dec_two)}
                         : {rotl(r_cd[0:27], w_enc_two), rotl(r_cd[28:55], w_enc_two)};
      end
    end
  end

  assign round_num = r_mode ? 4'(5'd16 - r_step) : 4'(r_step - 5'd1);
  assign round_key = (RK_CLEAR && !rk_valid) ? '0 : pc2(r_cd);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// tb_des_key_schedule_seq
// Directed bench for des_key_schedule_seq using the FIPS 46-3 worked
// example key 0x133457799BBCDFF1 (round keys listed in K_TAB), plus a
// random-key / random-backpressure pass checked against an independent
// model that derives each Cn/Dn from C0/D0 by its cumulative shift.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at that same point.
module tb_des_key_schedule_seq;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [0:63] key;
  logic        decrypt;
  logic [0:47] round_key;
  logic [3:0]  round_num;
  logic        rk_valid;
  logic        rk_ready;
  logic        done;
  logic        parity_err;
  logic        dbg_state;

  int n_tests;
  int n_fail;

  localparam logic [0:63] KEY0    = 64'h133457799BBCDFF1;
  localparam logic [0:63] KEY_BAD = 64'h133457799BBCDFF0;

  localparam logic [47:0] K_TAB [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  localparam int TB_PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int TB_PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  des_key_schedule_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key        (key),
    .decrypt    (decrypt),
    .round_key  (round_key),
    .round_num  (round_num),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .done       (done),
    .parity_err (parity_err),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // Reference round key Kn (n = 1..16): C0/D0 rotated left by the
  // cumulative shift of rounds 1..n, then PC-2.
  function automatic logic [0:47] ref_rk(input logic [0:63] k, input int n);
    logic [0:55] cd0;
    logic [0:27] c0, d0, cn, dn;
    logic [0:55] cdn;
    logic [0:47] rk;
    int tot;
    cd0 = '0;
    for (int j = 0; j < 56; j++) cd0[j] = k[6'(TB_PC1[j] - 1)];
    c0 = cd0[0:27];
    d0 = cd0[28:55];
    tot = 0;
    for (int r = 1; r <= n; r++) tot += ((r == 1) || (r == 2) || (r == 9) || (r == 16)) ? 1 : 2;
    cn = '0;
    dn = '0;
    for (int b = 0; b < 28; b++) begin
      cn[b] = c0[5'((b + tot) % 28)];
      dn[b] = d0[5'((b + tot) % 28)];
    end
    cdn = {cn, dn};
    rk = '0;
    for (int j = 0; j < 48; j++) rk[j] = cdn[6'(TB_PC2[j] - 1)];
    return rk;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_valid = 1'b0;
    key = '0;
    decrypt = 1'b0;
    rk_ready = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || done !== 1'b0 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: key_ready=%b rk_valid=%b done=%b parity_err=%b, need 1 0 0 0",
               key_ready, rk_valid, done, parity_err);
    end
    n_tests++;
    if (round_num !== 4'd0 || round_key !== 48'h0 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: round_num=%0d round_key=%h dbg_state=%b, need 0 0 0",
               round_num, round_key, dbg_state);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || round_key !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_release: key_ready=%b rk_valid=%b round_key=%h, need 1 0 0",
               key_ready, rk_valid, round_key);
    end
  endtask

  // Full sequence for KEY0 with rk_ready held high. Returns in the done
  // cycle. With glitch set, key_valid is pulsed with another key mid-run.
  task automatic test_sequence(input logic dec, input bit glitch, input string tag);
    int wait_c;
    int idx;
    wait_c = 0;
    while (key_ready !== 1'b1 && wait_c < 50) begin
      tick();
      wait_c++;
    end
    n_tests++;
    if (key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_key_ready: key_ready=%b, need 1", tag, key_ready);
    end
    key = KEY0;
    decrypt = dec;
    key_valid = 1'b1;
    rk_ready = 1'b1;
    tick();
    key_valid = 1'b0;
    key = ~KEY0;
    decrypt = ~dec;
    for (int n = 0; n < 16; n++) begin
      idx = dec ? 15 - n : n;
      n_tests++;
      if (rk_valid !== 1'b1 || round_num !== 4'(idx) || round_key !== K_TAB[idx]) begin
        n_fail++;
        $display("FAIL %s_rk step %0d: rk_valid=%b round_num=%0d round_key=%h, need 1 %0d %h",
                 tag, n, rk_valid, round_num, round_key, idx, K_TAB[idx]);
      end
      if (glitch && (n == 3 || n == 4)) begin
        key_valid = 1'b1;
        key = 64'hFEDCBA9876543210;
        n_tests++;
        if (key_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_busy: key_ready=%b in RUN, need 0", tag, key_ready);
        end
      end else begin
        key_valid = 1'b0;
      end
      tick();
    end
    key_valid = 1'b0;
    n_tests++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: done=%b rk_valid=%b key_ready=%b, need 1 0 1",
               tag, done, rk_valid, key_ready);
    end
  endtask

  task automatic test_encrypt();
    test_sequence(1'b0, 1'b0, "enc");
    rk_ready = 1'b0;
    tick();
    n_tests++;
    if (done !== 1'b0 || round_key !== 48'h0) begin
      n_fail++;
      $display("FAIL enc_after: done=%b round_key=%h, need 0 0", done, round_key);
    end
  endtask

  task automatic test_decrypt();
    test_sequence(1'b1, 1'b0, "dec");
    rk_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    test_sequence(1'b0, 1'b0, "b2b_enc");
    n_tests++;
    if (done !== 1'b1 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_window: done=%b key_ready=%b, need 1 1", done, key_ready);
    end
    test_sequence(1'b1, 1'b0, "b2b_dec");
    rk_ready = 1'b0;
    tick();
  endtask

  task automatic test_ignore_key_valid();
    test_sequence(1'b0, 1'b1, "ign");
    rk_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    key = KEY0;
    decrypt = 1'b0;
    key_valid = 1'b1;
    rk_ready = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (rk_valid !== 1'b1 || round_num !== 4'd5 || round_key !== K_TAB[5]) begin
      n_fail++;
      $display("FAIL rst_mid_pre: rk_valid=%b round_num=%0d round_key=%h, need 1 5 %h",
               rk_valid, round_num, round_key, K_TAB[5]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || round_key !== 48'h0 || done !== 1'b0 || round_num !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid: rk_valid=%b key_ready=%b round_key=%h done=%b round_num=%0d, need 0 1 0 0 0",
               rk_valid, key_ready, round_key, done, round_num);
    end
    rk_ready = 1'b0;
    tick();
    n_tests++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_nodone: done=%b rk_valid=%b, need 0 0", done, rk_valid);
    end
    test_sequence(1'b1, 1'b0, "rst_fresh");
    rk_ready = 1'b0;
    tick();
  endtask

  task automatic test_parity();
    key = KEY_BAD;
    decrypt = 1'b0;
    key_valid = 1'b1;
    rk_ready = 1'b1;
    tick();
    key_valid = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
    n_tests++;
    if (parity_err !== 1'b1 || rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_reject: parity_err=%b rk_valid=%b key_ready=%b, need 1 0 1",
               parity_err, rk_valid, key_ready);
    end
    tick();
    n_tests++;
    if (parity_err !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_after: parity_err=%b rk_valid=%b done=%b, need 0 0 0",
               parity_err, rk_valid, done);
    end
`else
    n_tests++;
    if (rk_valid !== 1'b1 || round_key !== K_TAB[0] || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_ignored: rk_valid=%b round_key=%h parity_err=%b, need 1 %h 0",
               rk_valid, round_key, parity_err, K_TAB[0]);
    end
    repeat (16) tick();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_ignored_done: done=%b, need 1", done);
    end
`endif
    rk_ready = 1'b0;
    tick();
  endtask

  task automatic test_random_stall();
    logic [0:63] k;
    logic        dec;
    logic [0:47] held_rk;
    logic [3:0]  held_rn;
    bit          stalled;
    int          got;
    int          cyc;
    int          exp_rn;
    held_rk = '0;
    held_rn = '0;
    for (int t = 0; t < 16; t++) begin
      k = {$urandom(), $urandom()};
      for (int b = 0; b < 8; b++) k[8*b+7] = ~(^k[8*b +: 7]);
      dec = (t % 2) == 1;
      rk_ready = 1'b0;
      cyc = 0;
      while (key_ready !== 1'b1 && cyc < 50) begin
        tick();
        cyc++;
      end
      key = k;
      decrypt = dec;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      got = 0;
      stalled = 1'b0;
      cyc = 0;
      while (got < 16 && cyc < 400) begin
        rk_ready = 1'($urandom_range(0, 1));
        if (stalled) begin
          n_tests++;
          if (rk_valid !== 1'b1 || round_key !== held_rk || round_num !== held_rn) begin
            n_fail++;
            $display("FAIL rand_hold key %0d: rk_valid=%b round_num=%0d round_key=%h, need 1 %0d %h",
                     t, rk_valid, round_num, round_key, held_rn, held_rk);
          end
        end
        stalled = 1'b0;
        if (rk_valid === 1'b1) begin
          if (rk_ready) begin
            exp_rn = dec ? 15 - got : got;
            n_tests++;
            if (round_num !== 4'(exp_rn) || round_key !== ref_rk(k, exp_rn + 1)) begin
              n_fail++;
              $display("FAIL rand_rk key %0d: round_num=%0d round_key=%h, need %0d %h",
                       t, round_num, round_key, exp_rn, ref_rk(k, exp_rn + 1));
            end
            got++;
          end else begin
            stalled = 1'b1;
            held_rk = round_key;
            held_rn = round_num;
          end
        end
        tick();
        cyc++;
      end
      n_tests++;
      if (got != 16 || done !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_done key %0d: keys=%0d done=%b, need 16 1", t, got, done);
      end
    end
    rk_ready = 1'b0;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    key_valid = 1'b0;
    key = '0;
    decrypt = 1'b0;
    rk_ready = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_back_to_back();
    test_ignore_key_valid();
    test_reset_mid_run();
    test_parity();
    test_random_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule_seq.md
Name: des_key_schedule_seq

Overview:
- Sequential DES key-schedule engine: accepts a 64-bit key and emits 16 48-bit round keys, one per output handshake.
- Encrypt order is K1..K16 (left rotations). Decrypt order is K16..K1 (right rotations, the reverse direction).
- Applies PC-1 and PC-2 per FIPS 46-3 internally, plus a 28+28-bit C/D rotator.
- Feeds the round datapath of the DES core; pairs with the existing combinational PC-2 selection stage.

Parameters:
- RK_CLEAR, 1: 1 = round_key forced to 0 while rk_valid is low; 0 = round_key holds its last value.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- key_valid  input  1  key offered
- key_ready  output  1  engine idle, will accept key
- key  input  [0:63]  DES key, bit 0 = MSB, parity bits at 7,15,...,63
- decrypt  input  1  sampled with key; 1 = emit K16..K1
- round_key  output  [0:47]  current round key
- round_num  output  [3:0]  round index of round_key (0 = K1 ... 15 = K16)
- rk_valid  output  1  round_key valid
- rk_ready  input  1  consumer accepts round_key
- done  output  1  one-cycle pulse after final key accepted
- parity_err  output  1  one-cycle pulse on rejected key (feature only)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state IDLE; key_ready=1, rk_valid=0, done=0, parity_err=0, round_num=0, round_key=0; C/D register=0.
- States: IDLE, RUN.
- IDLE:
  - key_ready=1.
  - On key_valid (accept at edge T): load CD = PC1(key). Encrypt additionally rotates left by 1 (shift for K1). Latch decrypt into mode. Go RUN.
- RUN:
  - rk_valid=1, key_ready=0.
  - round_key = PC2(CD); output comes from register state, no combinational path from rk_ready.
  - First key valid at T+1.
- Shift schedule s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt advance:
  - Step counter i runs 1..16; round_num = i-1.
  - On rk_valid&&rk_ready with i<16: C and D each rotate left by s[i+1]; i++.
- Decrypt advance:
  - First key uses PC1(key) unrotated; total shift 28 means C16/D16 = C0/D0, so this is K16.
  - round_num = 16-i.
  - On handshake with i<16: C and D each rotate right by s[17-i]; i++.
- Rotations are independent on the 28-bit C and D halves and never cross halves.
- Final handshake (i=16):
  - Go IDLE, rk_valid=0 next cycle, key_ready=1 next cycle.
  - done=1 for exactly that next cycle.
  - Back-to-back: a new key may be accepted in the cycle done is high.
- Backpressure: with rk_ready=0, round_key, round_num and CD hold indefinitely.
- key_valid while in RUN is ignored: not accepted, no effect.
- decrypt changes after acceptance have no effect.
- rst in any state, including mid-RUN, returns to reset values next edge. No done pulse; partial sequence discarded.
- Throughput: one key per cycle with rk_ready held high. Full sequence occupies 16 cycles, T+1..T+16.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- Defined:
  - At acceptance, each key byte must have odd parity.
  - On failure: key is consumed (handshake completes), state stays IDLE, parity_err=1 for one cycle, no round keys emitted.
- Undefined: parity bits ignored, parity_err tied 0.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, rk_ready=1 -> rk_valid T+1..T+16; round_num 0 gives 0x1B02EFFC7072; round_num 1 gives 0x79AED9DBC9E5; round_num 15 gives 0xCB3D8B0E17F5; done at T+17.
- Decrypt, same key -> first key (round_num 15) 0xCB3D8B0E17F5; last key (round_num 0) 0x1B02EFFC7072; sequence equals encrypt sequence reversed.
- Random rk_ready toggling over 16 random keys, both modes -> every key matches reference model; values held stable while stalled; no key skipped or duplicated.
- rst asserted after the 5th handshake -> next cycle rk_valid=0, key_ready=1, round_key=0; a fresh key then yields a correct full sequence.
- key_valid pulsed mid-RUN with a different key -> ignored; current sequence unchanged.
- With DES_KEY_PARITY_CHECK_EN, key 0x133457799BBCDFF0 -> parity_err pulse, rk_valid stays 0. Without the macro -> K1 = 0x1B02EFFC7072, since parity bits are dropped by PC-1.
